majority_debounce_timer: RTL and testbench

//  Downstream consumer of the registered 8-input majority vote bit.
//  - Debounces the vote: it must hold for STABLE_CYCLES samples before the filtered level changes.
//  - Emits one-cycle rise/fall pulses on each filtered edge.
//  - Measures each filtered-high episode in gclk cycles and offers the length on a valid/ready report port.

---
 rtl/maj_filt_pkg.sv | 26 ++
 rtl/maj_debounce_fsm.sv | 116 +++++++++++
 rtl/majority_debounce_timer.sv | 141 ++++++++++++++
 tb/tb_majority_debounce_timer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maj_filt_pkg.sv
// maj_filt_pkg
// Shared types and defaults for the majority debounce / episode timer slice.
//   deb_state_t        debounce FSM states (LOW, PEND_H, HIGH, PEND_L)
//   DEF_STABLE_CYCLES  default number of identical samples needed to switch level
//   DEF_CNT_W          default width of the episode-length counter
//   STAB_W             stability-counter width for the default configuration
//   stab_width()       stability-counter width for any STABLE_CYCLES value
package maj_filt_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    PEND_H = 2'd1,
    HIGH   = 2'd2,
    PEND_L = 2'd3
  } deb_state_t;

  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 16;
  localparam int STAB_W            = $clog2(DEF_STABLE_CYCLES + 1);

  // The counter must be able to hold STABLE_CYCLES itself, hence the +1.
  function automatic int stab_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/maj_debounce_fsm.sv
// maj_debounce_fsm
// Debounces the registered majority bit: the filtered level only changes once
// the opposite value has been seen for STABLE_CYCLES consecutive samples.
// Ports:
//   gclk        in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   maj_in      in   registered majority bit
//   clr         in   synchronous clear back to the reset state
//   filt_out    out  debounced level (registered, 1 in HIGH and PEND_L)
//   rise_pulse  out  registered one-cycle pulse on filt_out 0->1
//   fall_pulse  out  registered one-cycle pulse on filt_out 1->0
//   rise_evt    out  combinational: the coming edge switches the level high
//   fall_evt    out  combinational: the coming edge switches the level low
module maj_debounce_fsm
  import maj_filt_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic gclk,
  input  logic resetn,
  input  logic maj_in,
  input  logic clr,
  output logic filt_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int              SW     = stab_width(STABLE_CYCLES);
  localparam logic [SW-1:0]   LAST   = SW'(STABLE_CYCLES - 1);
  // With a single required sample the pending states are skipped entirely.
  localparam logic            DIRECT = (STABLE_CYCLES == 1);

  deb_state_t    state;
  logic [SW-1:0] stab_cnt;

  // The switching edge is the one on which stab_cnt would reach STABLE_CYCLES,
  // i.e. the current count already equals STABLE_CYCLES-1. The top level needs
  // these before the edge to close or open an episode on that same edge.
  assign rise_evt = !clr && maj_in &&
                    ((state == LOW && DIRECT) || (state == PEND_H && stab_cnt == LAST));
  assign fall_evt = !clr && !maj_in &&
                    ((state == HIGH && DIRECT) || (state == PEND_L && stab_cnt == LAST));

  always_ff @(posedge gclk or negedge resetn) begin
    if (!resetn) begin
      state      <= LOW;
      stab_cnt   <= '0;
      filt_out   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise_evt;
      fall_pulse <= fall_evt;
      if (clr) begin
        state    <= LOW;
        stab_cnt <= '0;
        filt_out <= 1'b0;
      end else begin
        case (state)
          LOW: begin
            if (rise_evt) begin
              state    <= HIGH;
              stab_cnt <= '0;
              filt_out <= 1'b1;
            end else if (maj_in) begin
              state    <= PEND_H;
              stab_cnt <= SW'(1);
            end
          end
          PEND_H: begin
            if (rise_evt) begin
              state    <= HIGH;
              stab_cnt <= '0;
              filt_out <= 1'b1;
            end else if (maj_in) begin
              stab_cnt <= stab_cnt + SW'(1);
            end else begin
              state    <= LOW;
              stab_cnt <= '0;
            end
          end
          HIGH: begin
            if (fall_evt) begin
              state    <= LOW;
              stab_cnt <= '0;
              filt_out <= 1'b0;
            end else if (!maj_in) begin
              state    <= PEND_L;
              stab_cnt <= SW'(1);
            end
          end
          PEND_L: begin
            if (fall_evt) begin
              state    <= LOW;
              stab_cnt <= '0;
              filt_out <= 1'b0;
            end else if (!maj_in) begin
              stab_cnt <= stab_cnt + SW'(1);
            end else begin
              state    <= HIGH;
              stab_cnt <= '0;
            end
          end
          default: begin
            state    <= LOW;
            stab_cnt <= '0;
            filt_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/majority_debounce_timer.sv
// majority_debounce_timer
// Debounces the majority vote bit, pulses on each filtered edge and measures
// every filtered-high episode in gclk cycles, offering the length on a
// single-entry valid/ready report port.
// Optional feature macro: MAJ_FILT_SAT_EN
//   defined   -> episode counter saturates at 2^CNT_W-1 and rpt_sat exists
//   undefined -> episode counter wraps modulo 2^CNT_W, no rpt_sat port
// Ports:
//   gclk        in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   maj_in      in   registered majority bit (same clock domain)
//   clr         in   synchronous clear of FSM, counters and report
//   filt_out    out  debounced majority level
//   rise_pulse  out  one-cycle pulse on filt_out 0->1
//   fall_pulse  out  one-cycle pulse on filt_out 1->0
//   rpt_valid   out  episode report available
//   rpt_ready   in   report accepted when rpt_valid & rpt_ready
//   rpt_count   out  length of the last completed high episode
//   rpt_sat     out  (MAJ_FILT_SAT_EN only) reported length saturated
//   rpt_drop    out  one-cycle pulse: episode finished while slot occupied
module majority_debounce_timer
  import maj_filt_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             gclk,
  input  logic             resetn,
  input  logic             maj_in,
  input  logic             clr,
  output logic             filt_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
`ifdef MAJ_FILT_SAT_EN
  output logic             rpt_sat,
`endif
  output logic             rpt_drop
);

  logic             rise_evt;
  logic             fall_evt;
  logic             accept;
  logic             slot_free;
  logic [CNT_W-1:0] dur;

  maj_debounce_fsm #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_fsm (
    .gclk      (gclk),
    .resetn    (resetn),
    .maj_in    (maj_in),
    .clr       (clr),
    .filt_out  (filt_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .rise_evt  (rise_evt),
    .fall_evt  (fall_evt)
  );

  assign accept    = rpt_valid & rpt_ready;
  // The slot counts as free when the pending report leaves on this very edge.
  assign slot_free = !rpt_valid | rpt_ready;

`ifdef MAJ_FILT_SAT_EN
  logic dur_sat;

  // Episode length: 1 on the rising edge, +1 for every further high cycle up
  // to the fall. Sticks at all-ones and remembers that it had to stop there.
  always_ff @(posedge gclk or negedge resetn) begin
    if (!resetn) begin
      dur     <= '0;
      dur_sat <= 1'b0;
    end else if (clr || fall_evt) begin
      dur     <= '0;
      dur_sat <= 1'b0;
    end else if (rise_evt) begin
      dur     <= CNT_W'(1);
      dur_sat <= 1'b0;
    end else if (filt_out) begin
      if (dur == '1) begin
        dur_sat <= 1'b1;
      end else begin
        dur <= dur + CNT_W'(1);
      end
    end
  end
`else
  // Episode length: 1 on the rising edge, +1 for every further high cycle up
  // to the fall; wraps naturally at the counter width.
  always_ff @(posedge gclk or negedge resetn) begin
    if (!resetn) begin
      dur <= '0;
    end else if (clr || fall_evt) begin
      dur <= '0;
    end else if (rise_evt) begin
      dur <= CNT_W'(1);
    end else if (filt_out) begin
      dur <= dur + CNT_W'(1);
    end
  end
`endif

  // Single-entry report slot. A finished episode is loaded only if the slot is
  // free (or being drained this edge); otherwise it is discarded and flagged.
  // rpt_count is never touched while a report is pending.
  always_ff @(posedge gclk or negedge resetn) begin
    if (!resetn) begin
      rpt_valid <= 1'b0;
      rpt_count <= '0;
      rpt_drop  <= 1'b0;
`ifdef MAJ_FILT_SAT_EN
      rpt_sat   <= 1'b0;
`endif
    end else begin
      rpt_drop <= 1'b0;
      if (clr) begin
        rpt_valid <= 1'b0;
        rpt_count <= '0;
`ifdef MAJ_FILT_SAT_EN
        rpt_sat   <= 1'b0;
`endif
      end else if (fall_evt) begin
        if (slot_free) begin
          rpt_valid <= 1'b1;
          rpt_count <= dur;
`ifdef MAJ_FILT_SAT_EN
          rpt_sat   <= dur_sat;
`endif
        end else begin
          rpt_drop <= 1'b1;
        end
      end else if (accept) begin
        rpt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_majority_debounce_timer.sv
// tb_majority_debounce_timer
// Scoreboard bench for majority_debounce_timer (STABLE_CYCLES=4, CNT_W=5).
// The reference model works on sample runs: the level flips once STABLE_CYCLES
// consecutive samples disagree with it, and an episode length is the number of
// edges after which the filtered level is high. Reports go into a queue that
// the monitor drains on every observed handshake.
module tb_majority_debounce_timer;

  localparam int SC   = 4;
  localparam int CW   = 5;
  localparam int MAXV = (1 << CW) - 1;

  typedef struct {
    bit filt;
    bit rise;
    bit fall;
    bit drop;
    bit valid;
    bit zero;
  } exp_t;

  typedef struct {
    int cnt;
    bit sat;
  } rep_t;

  logic          gclk;
  logic          resetn;
  logic          maj_in;
  logic          clr;
  logic          filt_out;
  logic          rise_pulse;
  logic          fall_pulse;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [CW-1:0] rpt_count;
  logic          rpt_drop;
`ifdef MAJ_FILT_SAT_EN
  logic          rpt_sat;
`endif

  int   checks;
  int   errors;
  int   pop_count;
  int   last_pop;
  exp_t cyc_q[$];
  rep_t rep_q[$];

  bit   m_filt;
  int   m_run;
  int   m_len;
  bit   m_valid;

  majority_debounce_timer #(
    .STABLE_CYCLES(SC),
    .CNT_W        (CW)
  ) dut (
    .gclk      (gclk),
    .resetn    (resetn),
    .maj_in    (maj_in),
    .clr       (clr),
    .filt_out  (filt_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_count (rpt_count),
`ifdef MAJ_FILT_SAT_EN
    .rpt_sat   (rpt_sat),
`endif
    .rpt_drop  (rpt_drop)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // Compare one value and log it if it disagrees.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_filt  = 1'b0;
    m_run   = 0;
    m_len   = 0;
    m_valid = 1'b0;
    rep_q.delete();
  endtask

  // Predict the effect of one clock edge with the given inputs.
  task automatic model_edge(input bit din, input bit rdy, input bit c, output exp_t e);
    bit   accept;
    bit   rose;
    bit   fell;
    rep_t r;
    e = '{default: 1'b0};
    if (c) begin
      model_reset();
      e.zero = 1'b1;
      return;
    end
    accept = m_valid && rdy;
    rose   = 1'b0;
    fell   = 1'b0;
    if (din != m_filt) m_run++;
    else m_run = 0;
    if (m_run == SC) begin
      m_filt = !m_filt;
      m_run  = 0;
      rose   = m_filt;
      fell   = !m_filt;
    end
    if (fell) begin
      if (!m_valid || accept) begin
`ifdef MAJ_FILT_SAT_EN
        r.sat = (m_len > MAXV);
        r.cnt = r.sat ? MAXV : m_len;
`else
        r.sat = 1'b0;
        r.cnt = m_len % (MAXV + 1);
`endif
        rep_q.push_back(r);
        m_valid = 1'b1;
      end else begin
        e.drop = 1'b1;
      end
      m_len = 0;
    end else begin
      if (rose) m_len = 1;
      else if (m_filt) m_len++;
      if (accept) m_valid = 1'b0;
    end
    e.filt  = m_filt;
    e.rise  = rose;
    e.fall  = fell;
    e.valid = m_valid;
  endtask

  // Drive one cycle of inputs on the falling edge and record the prediction.
  task automatic applyStimulus(input bit din, input bit rdy, input bit c);
    exp_t e;
    @(negedge gclk);
    maj_in    = din;
    rpt_ready = rdy;
    clr       = c;
    model_edge(din, rdy, c, e);
    cyc_q.push_back(e);
  endtask

  task automatic run(input bit din, input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(din, rdy, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge gclk);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    checkOutput("arst_filt_out", filt_out, 0);
    checkOutput("arst_rpt_valid", rpt_valid, 0);
    checkOutput("arst_rpt_count", rpt_count, 0);
    checkOutput("arst_rise_pulse", rise_pulse, 0);
    checkOutput("arst_fall_pulse", fall_pulse, 0);
    repeat (2) @(negedge gclk);
    #2;
    resetn = 1'b1;
  endtask

  // Monitor: per-edge flags after each rising edge, report contents whenever a
  // handshake is set up for the coming edge.
  initial begin : monitor
    exp_t e;
    rep_t r;
    forever begin
      @(posedge gclk);
      #1;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        checkOutput("filt_out", filt_out, e.filt);
        checkOutput("rise_pulse", rise_pulse, e.rise);
        checkOutput("fall_pulse", fall_pulse, e.fall);
        checkOutput("rpt_drop", rpt_drop, e.drop);
        checkOutput("rpt_valid", rpt_valid, e.valid);
        if (e.zero) checkOutput("clr_rpt_count", rpt_count, 0);
      end
      @(negedge gclk);
      #1;
      if (resetn && !clr && rpt_valid && rpt_ready) begin
        if (rep_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_report: got count %0d expected no report at %0t", rpt_count, $time);
        end else begin
          r = rep_q.pop_front();
          checkOutput("rpt_count", rpt_count, r.cnt);
`ifdef MAJ_FILT_SAT_EN
          checkOutput("rpt_sat", rpt_sat, r.sat);
`endif
          last_pop = rpt_count;
          pop_count++;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    int  pc0;
    int  len;
    bit  val;
    bit  stall;
    bit  rdy;
    bit  c;
    checks    = 0;
    errors    = 0;
    pop_count = 0;
    last_pop  = -1;
    resetn    = 1'b0;
    maj_in    = 1'b0;
    clr       = 1'b0;
    rpt_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge gclk);
    checkOutput("rst_filt_out", filt_out, 0);
    checkOutput("rst_rise_pulse", rise_pulse, 0);
    checkOutput("rst_fall_pulse", fall_pulse, 0);
    checkOutput("rst_rpt_valid", rpt_valid, 0);
    checkOutput("rst_rpt_count", rpt_count, 0);
    checkOutput("rst_rpt_drop", rpt_drop, 0);
    #3;
    resetn = 1'b1;

    $display("[TB] short high burst below threshold");
    run(1'b1, 3, 1'b1);
    run(1'b0, 3, 1'b1);

    $display("[TB] single 10-cycle episode");
    pc0 = pop_count;
    run(1'b1, 10, 1'b1);
    run(1'b0, 4, 1'b1);
    run(1'b0, 2, 1'b1);
    #2;
    checkOutput("t2_count", last_pop, 10);
    checkOutput("t2_reports", pop_count - pc0, 1);

    $display("[TB] second episode dropped while report pending");
    pc0 = pop_count;
    run(1'b1, 6, 1'b0);
    run(1'b0, 4, 1'b0);
    run(1'b1, 8, 1'b0);
    run(1'b0, 4, 1'b0);
    run(1'b0, 2, 1'b1);
    #2;
    checkOutput("t3_count", last_pop, 6);
    checkOutput("t3_reports", pop_count - pc0, 1);

    $display("[TB] fall coincides with acceptance");
    pc0 = pop_count;
    run(1'b1, 5, 1'b0);
    run(1'b0, 4, 1'b0);
    run(1'b1, 7, 1'b0);
    run(1'b0, 3, 1'b0);
    run(1'b0, 1, 1'b1);
    run(1'b0, 2, 1'b1);
    #2;
    checkOutput("t4_count", last_pop, 7);
    checkOutput("t4_reports", pop_count - pc0, 2);

    $display("[TB] episode longer than counter range");
    pc0 = pop_count;
    run(1'b1, 37, 1'b1);
    run(1'b0, 4, 1'b1);
    run(1'b0, 2, 1'b1);
    #2;
`ifdef MAJ_FILT_SAT_EN
    checkOutput("t5_count", last_pop, MAXV);
`else
    checkOutput("t5_count", last_pop, 37 % 32);
`endif
    checkOutput("t5_reports", pop_count - pc0, 1);

    $display("[TB] synchronous clear mid-episode");
    pc0 = pop_count;
    run(1'b1, 8, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    run(1'b0, 6, 1'b1);
    run(1'b1, 6, 1'b1);
    run(1'b0, 4, 1'b1);
    run(1'b0, 2, 1'b1);
    #2;
    checkOutput("t6_clr_count", last_pop, 6);
    checkOutput("t6_clr_reports", pop_count - pc0, 1);

    $display("[TB] asynchronous reset mid-episode");
    pc0 = pop_count;
    run(1'b1, 8, 1'b1);
    async_reset();
    run(1'b0, 6, 1'b1);
    run(1'b1, 9, 1'b1);
    run(1'b0, 4, 1'b1);
    run(1'b0, 2, 1'b1);
    #2;
    checkOutput("t6_arst_count", last_pop, 9);
    checkOutput("t6_arst_reports", pop_count - pc0, 1);

    $display("[TB] randomized runs");
    val = 1'b0;
    for (int r = 0; r < 80; r++) begin
      val   = ~val;
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) len = $urandom_range(30, 45);
      else len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        rdy = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
        c   = ($urandom_range(0, 249) == 0);
        applyStimulus(val, rdy, c);
      end
    end

    run(1'b0, 8, 1'b1);
    #2;
    checkOutput("reports_drained", rep_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
